// File: rtl/perf_latmon_if.sv
// perf_latmon_if: Wishbone slave register port plus the observed master handshake
interface perf_latmon_if;
    logic        s_cyc_i;
    logic        s_stb_i;
    logic        s_we_i;
    logic [31:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic        s_rty_o;
    logic        s_err_o;
    logic        m_cyc;
    logic        m_stb;
    logic        m_ack;

    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_dat_i, m_cyc, m_stb, m_ack,
        output s_dat_o, s_ack_o, s_rty_o, s_err_o
    );

    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_dat_i, m_cyc, m_stb, m_ack,
        input  s_dat_o, s_ack_o, s_rty_o, s_err_o
    );
endinterface

// File: rtl/perf_latmon.sv
// perf_latmon: measures per-transaction latency of an observed bus, exposes statistics over Wishbone
module perf_latmon #(
    parameter logic [31:0] BASE_ADR = 32'h99000020,
    parameter int          LAT_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    perf_latmon_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [LAT_W-1:0] LAT_SAT = '1;

    state_t           state;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] fin_lat;
    logic [LAT_W-1:0] lat_max;
    logic [31:0]      txn_cnt;
    logic [31:0]      lat_sum;
    logic [31:0]      lat_min;
    logic [31:0]      fin_ext;
    logic [32:0]      sum_ext;
    logic             enable;
    logic             ovf;
    logic             ack;
    logic             addr_match;
    logic             wr;
    logic             clear;
    logic             req;
    logic             done;
    logic [2:0]       idx;
    logic             unused;

    assign idx         = bus.s_adr_i[4:2];
    assign addr_match  = bus.s_adr_i[31:5] == BASE_ADR[31:5];
    assign wr          = ack && bus.s_cyc_i && bus.s_stb_i && bus.s_we_i && addr_match;
    assign clear       = wr && idx == 3'd0 && bus.s_dat_i[1];
    assign req         = bus.m_cyc && bus.m_stb;
    assign lat_inc     = lat == LAT_SAT ? lat : lat + 1'b1;
    // An ack in IDLE is a single-cycle transaction; in WAIT the ack cycle itself still counts
    assign done        = enable && bus.m_ack && (state == WAIT || req);
    assign fin_lat     = state == WAIT ? lat_inc : LAT_W'(1);
    assign fin_ext     = 32'(fin_lat);
    assign sum_ext     = {1'b0, lat_sum} + {1'b0, fin_ext};
    assign bus.s_ack_o = ack;
    assign bus.s_rty_o = 1'b0;
    assign bus.s_err_o = 1'b0;
    assign unused      = ^{bus.s_dat_i[31:2], bus.s_adr_i[1:0]};

    // Track one monitored transaction at a time and count its cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lat   <= '0;
        end else if (clear || !enable) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (req && !bus.m_ack) begin
                state <= WAIT;
                lat   <= LAT_W'(1);
            end
        end else if (bus.m_ack || !bus.m_cyc) begin
            state <= IDLE;
        end else begin
            lat <= lat_inc;
        end
    end

    // Fold each completed transaction into the statistics; CLEAR wins over a completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= '0;
            lat_sum <= '0;
            lat_max <= '0;
            lat_min <= '1;
            ovf     <= 1'b0;
        end else if (clear) begin
            txn_cnt <= '0;
            lat_sum <= '0;
            lat_max <= '0;
            lat_min <= '1;
            ovf     <= 1'b0;
        end else if (done) begin
            txn_cnt <= txn_cnt + 1'b1;
            lat_sum <= sum_ext[32] ? '1 : sum_ext[31:0];
            ovf     <= ovf | sum_ext[32];
            lat_max <= fin_lat > lat_max ? fin_lat : lat_max;
            lat_min <= fin_ext < lat_min ? fin_ext : lat_min;
        end
    end

    // Single-cycle slave ack that never repeats back to back, plus the ENABLE bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= 1'b0;
            enable <= 1'b0;
        end else begin
            ack <= bus.s_cyc_i && bus.s_stb_i && addr_match && !ack;
            if (wr && idx == 3'd0) enable <= bus.s_dat_i[0];
        end
    end

    // Combinational read mux over the register window
    always_comb begin
        case (idx)
            3'd0:    bus.s_dat_o = {31'b0, enable};
            3'd1:    bus.s_dat_o = txn_cnt;
            3'd2:    bus.s_dat_o = lat_sum;
            3'd3:    bus.s_dat_o = 32'(lat_max);
            3'd4:    bus.s_dat_o = lat_min;
            3'd5:    bus.s_dat_o = {30'b0, ovf, state == WAIT};
            default: bus.s_dat_o = '0;
        endcase
    end
endmodule

// File: doc/perf_latmon.md
PERF_LATMON -- requirements
Module: perf_latmon

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h99000020, Wishbone byte base address of the register window.
REQ-002 SHALL have parameter LAT_W, default 16, width of the per-transaction latency counter.
REQ-003 SHALL have port clk  in  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_cyc_i / s_stb_i / s_we_i  in  1 each  slave Wishbone control signals.
REQ-006 SHALL have port s_adr_i  in  32  slave byte address.
REQ-007 SHALL have port s_dat_i  in  32  slave write data.
REQ-008 SHALL have port s_dat_o  out  32  slave read data.
REQ-009 SHALL have port s_ack_o  out  1  slave acknowledge; s_rty_o and s_err_o (out, 1 each) are tied to 0.
REQ-010 SHALL have port m_cyc / m_stb / m_ack  in  1 each  monitored master bus signals, observe only.

Function
REQ-011 SHALL measure bus latency on the monitored port: the count runs from the first m_cyc&&m_stb cycle through the m_ack cycle, both inclusive, so an ack in the first cycle gives latency 1.
REQ-012 SHALL implement a state machine with states IDLE and WAIT.
- IDLE -> WAIT when enable=1, m_cyc&&m_stb and !m_ack; lat <= 1.
- IDLE with enable=1, m_cyc&&m_stb and m_ack: completes with latency 1 and stays in IDLE.
- WAIT: lat increments each cycle, saturating at 2^LAT_W-1.
- WAIT -> IDLE on m_ack (complete), or on !m_cyc (abort).
REQ-013 SHALL, on completion, update the statistics in the same edge:
- TXN_CNT += 1;
- LAT_SUM += final latency, saturating at 32'hFFFFFFFF, and setting sticky OVF on saturation;
- LAT_MAX = max(LAT_MAX, latency);
- LAT_MIN = min(LAT_MIN, latency).
REQ-014 SHALL leave every statistic unchanged on an abort.
REQ-015 SHALL treat back-to-back transactions (m_ack followed by m_stb next cycle) as separate transactions, with no lost cycle.
REQ-016 SHALL decode registers at BASE_ADR + s_adr_i[4:2]*4; s_adr_i[31:5] must match BASE_ADR[31:5].
- 0 CTRL (rw): bit0 ENABLE, bit1 CLEAR (write-only, reads 0).
- 1 TXN_CNT (ro)
- 2 LAT_SUM (ro)
- 3 LAT_MAX (ro, zero-extended)
- 4 LAT_MIN (ro, zero-extended)
- 5 STATUS (ro): bit0 BUSY (state==WAIT), bit1 OVF.
- 6-7 read as 0.
REQ-017 SHALL drive s_dat_o combinationally from the decoded register.
REQ-018 SHALL register s_ack_o as s_cyc_i&&s_stb_i&&addr_match&&!s_ack_o, giving a one-cycle pulse with latency 1 and no double ack.
REQ-019 SHALL perform a register write on the s_ack_o cycle when s_we_i=1; writes to read-only addresses are ignored but still acked.
REQ-020 SHALL, on a write of CTRL with bit1=1, reset TXN_CNT, LAT_SUM, LAT_MAX and OVF to 0, reset LAT_MIN to all ones, and return the FSM to IDLE at that edge. CLEAR overrides a completion in the same cycle.
REQ-021 SHALL, while ENABLE=0, hold the FSM in IDLE and freeze the statistics; clearing ENABLE while in WAIT discards the in-flight transaction.
REQ-022 SHALL leave s_adr_i and s_stb_i unacked when the address is outside the window.

Reset
REQ-023 SHALL, on rst_n low (asynchronous), set: state IDLE, lat 0, ENABLE 0, TXN_CNT 0, LAT_SUM 0, LAT_MAX 0, LAT_MIN all ones, OVF 0, s_ack_o 0.
REQ-024 SHALL drive s_dat_o from the reset register values while rst_n is low; reset asserted mid-transaction discards that transaction.

Verification
REQ-025 SHALL cover: ENABLE=1, transactions with m_ack at cycle 1, 3 and 5 -> TXN_CNT=3, LAT_SUM=9, LAT_MAX=5, LAT_MIN=1.
REQ-026 SHALL cover: m_stb held 4 cycles then m_cyc drops without m_ack -> TXN_CNT=0, BUSY returns to 0, LAT_MIN=32'hFFFFFFFF.
REQ-027 SHALL cover: back-to-back pair of 2-cycle transactions -> TXN_CNT=2, LAT_SUM=4.
REQ-028 SHALL cover: CLEAR written in the same cycle as m_ack -> all statistics at their clear values afterwards.
REQ-029 SHALL cover: LAT_SUM preloaded near saturation by a long run (LAT_W=16, repeated 65535-cycle waits) -> LAT_SUM=32'hFFFFFFFF and OVF=1.
REQ-030 SHALL cover: slave read of STATUS with s_stb_i held 3 cycles -> s_ack_o pulses on cycles 2 and 4, never on consecutive cycles; rst_n pulsed low asynchronously mid-WAIT -> all registers return to their reset values immediately.
